// File: rtl/alu_cmd_sequencer.sv
// Queues host ALU commands, fetches operands from a small register file, drives the external ALU, writes back F.
// Latency: command pushed into an idle, empty sequencer -> res_valid high 3 edges later; at most 1 result per 4 cycles.
// Backpressure: res_ready low holds the result in RESP; the command FIFO keeps accepting until full (cmd_ready=0).
module alu_cmd_sequencer #(
  parameter int DATA_W     = 8,
  parameter int NUM_REGS   = 4,
  parameter int REG_AW     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [3:0]        alu_instruction,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_f,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       ops_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [3:0]        op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  cmd_t              r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rf [NUM_REGS];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_alu_op;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [REG_AW-1:0] r_cur_rd;
  logic [DATA_W-1:0] r_res_data;
  logic [REG_AW-1:0] r_res_rd;
  logic              r_res_valid;
  logic [15:0]       r_ops_done;

  cmd_t w_cmd_in;
  cmd_t w_head;
  logic w_push;
  logic w_pop;
  logic w_accept;

  assign w_cmd_in = '{op: cmd_op, rd: cmd_rd, ra: cmd_ra, rb: cmd_rb,
                      imm_en: cmd_imm_en, imm: cmd_imm};
  assign w_head   = r_fifo[r_rd_ptr];

  // Full is the only refusal condition; a pop in the same edge cannot help because ready is registered-count based.
  assign cmd_ready = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);
  assign w_accept  = (r_state == S_RESP) && res_ready;

  assign alu_instruction = r_alu_op;
  assign alu_a           = r_alu_a;
  assign alu_b           = r_alu_b;
  assign res_valid       = r_res_valid;
  assign res_data        = r_res_data;
  assign res_rd          = r_res_rd;
  assign ops_done        = r_ops_done;
  assign busy            = (r_state != S_IDLE) || (r_count != '0);
  assign dbg_data        = r_rf[dbg_addr];

  // FIFO payload storage; a write during reset is harmless because pointers and count stay cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_cmd_in;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: one settle cycle for the ALU, one capture cycle, then wait for the consumer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_pop) w_state_nxt = S_ISSUE;
      S_ISSUE:   w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_RESP;
      S_RESP:    if (res_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Operand fetch at pop, result capture, handshake and completion count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op    <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_cur_rd    <= '0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
      r_res_valid <= 1'b0;
      r_ops_done  <= '0;
    end else begin
      if (w_pop) begin
        r_alu_op <= w_head.op;
        r_alu_a  <= r_rf[w_head.ra];
        r_alu_b  <= w_head.imm_en ? w_head.imm : r_rf[w_head.rb];
        r_cur_rd <= w_head.rd;
      end
      if (r_state == S_CAPTURE) begin
        r_res_data  <= alu_f;
        r_res_rd    <= r_cur_rd;
        r_res_valid <= 1'b1;
      end
      if (w_accept) begin
        r_res_valid <= 1'b0;
        r_ops_done  <= r_ops_done + 16'd1;
      end
    end
  end

  // Register file writeback lands before the FSM can return to IDLE, so the next pop sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_rf[r_cur_rd] <= alu_f;
    end
  end

endmodule
